// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID->EX pipeline register.
//   NOP_ALUC_DEF : aluc code shown to execute when no instruction is valid;
//                  it matches no type code, so execute never writes rd or PC.
//   IDEX_W       : width of one packed decoded-instruction payload.
//   idex_t       : field layout of that payload.
package id_ex_pipe_pkg;

  localparam logic [3:0] NOP_ALUC_DEF = 4'b0000;
  localparam int         CNT_W_DEF    = 16;
  localparam int         IDEX_W       = 4 + 8 + 5 + 1 + 32 + 32 + 32;

  typedef struct packed {
    logic [3:0]  aluc;
    logic [7:0]  alucex;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
  } idex_t;

endpackage

// File: rtl/id_ex_pipe_slot.sv
// One payload register with a valid bit (used for both the main and skid entry).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture d and set valid (wins over clear)
//   clear      : drop valid, payload kept
//   d          : incoming payload
//   valid, q   : registered valid and payload
module idex_slot
  import id_ex_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  clear,
  input  idex_t d,
  output logic  valid,
  output idex_t q
);

  logic  valid_q, valid_d;
  idex_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/id_ex_pipe.sv
// Elastic ID->EX pipeline register with a two-entry skid buffer.
// The main entry M drives the id_ex_* bus; the skid entry S absorbs the one
// instruction decode may send in the cycle execute stalls, so id_ready comes
// straight from a flop. A consumed entry with ex_redirect kills everything
// behind it and the kills are counted in a saturating counter.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   id_valid/id_ready      : decode handshake (id_ready registered)
//   id_*                   : decoded instruction payload
//   id_ex_valid            : output entry valid
//   ex_ready, ex_redirect  : execute consumes / redirects PC on the output entry
//   id_ex_*                : payload to execute, masked to a NOP when invalid
//   kill_cnt               : saturating count of squashed instructions
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter logic [3:0] NOP_ALUC = NOP_ALUC_DEF,
  parameter int         CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [3:0]       id_aluc,
  input  logic [7:0]       id_alucex,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rd_wen,
  input  logic [31:0]      id_rs1_data,
  input  logic [31:0]      id_rs2_data,
  input  logic [31:0]      id_pc,
  output logic             id_ex_valid,
  input  logic             ex_ready,
  input  logic             ex_redirect,
  output logic [3:0]       id_ex_aluc,
  output logic [7:0]       id_ex_alucex,
  output logic [4:0]       id_ex_rd_addr,
  output logic             id_ex_rd_wen,
  output logic [31:0]      id_ex_rs1_data,
  output logic [31:0]      id_ex_rs2_data,
  output logic [31:0]      id_ex_pc,
  output logic [CNT_W-1:0] kill_cnt
);

  localparam int SUM_W = CNT_W + 1;

  idex_t id_pl, m_din, m_q, s_q;
  logic  m_valid, s_valid;
  logic  m_load, m_clear, s_load, s_clear;
  logic  accept, consume, flush;
  logic  s_valid_next;
  logic  id_ready_q, id_ready_d;
  logic [1:0]       kill_inc;
  logic [SUM_W-1:0] kill_sum;
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

  assign id_pl = '{aluc: id_aluc, alucex: id_alucex, rd_addr: id_rd_addr,
                   rd_wen: id_rd_wen, rs1_data: id_rs1_data,
                   rs2_data: id_rs2_data, pc: id_pc};

  assign accept  = id_valid & id_ready_q;
  assign consume = m_valid & ex_ready;
  assign flush   = consume & ex_redirect;

  always_comb begin
    m_load   = 1'b0;
    m_clear  = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    m_din    = id_pl;
    kill_inc = 2'd0;
    if (flush) begin
      // The redirecting instruction itself retires; everything younger dies.
      m_clear  = 1'b1;
      s_clear  = 1'b1;
      kill_inc = {1'b0, s_valid} + {1'b0, accept};
    end else if (!m_valid || consume) begin
      if (s_valid) begin
        // accept cannot happen here: id_ready is low while S is full.
        m_load  = 1'b1;
        m_din   = s_q;
        s_clear = 1'b1;
      end else if (accept) begin
        m_load  = 1'b1;
      end else begin
        m_clear = 1'b1;
      end
    end else if (accept) begin
      s_load = 1'b1;
    end
  end

  // Look ahead at S so the registered id_ready tracks ~s_valid exactly.
  assign s_valid_next = s_load | (s_valid & ~s_clear);
  assign id_ready_d   = ~s_valid_next;

  assign kill_sum   = {1'b0, kill_cnt_q} + SUM_W'(kill_inc);
  assign kill_cnt_d = kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ready_q <= 1'b1;
      kill_cnt_q <= '0;
    end else begin
      id_ready_q <= id_ready_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  idex_slot u_m (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_din),
    .valid (m_valid),
    .q     (m_q)
  );

  idex_slot u_s (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s_load),
    .clear (s_clear),
    .d     (id_pl),
    .valid (s_valid),
    .q     (s_q)
  );

  assign id_ready       = id_ready_q;
  assign kill_cnt       = kill_cnt_q;
  assign id_ex_valid    = m_valid;
  assign id_ex_aluc     = m_valid ? m_q.aluc : NOP_ALUC;
  assign id_ex_alucex   = m_valid ? m_q.alucex : 8'd0;
  assign id_ex_rd_addr  = m_valid ? m_q.rd_addr : 5'd0;
  assign id_ex_rd_wen   = m_valid & m_q.rd_wen;
  assign id_ex_rs1_data = m_valid ? m_q.rs1_data : 32'd0;
  assign id_ex_rs2_data = m_valid ? m_q.rs2_data : 32'd0;
  assign id_ex_pc       = m_valid ? m_q.pc : 32'd0;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

  localparam int         CNT_W = 2;
  localparam logic [3:0] NOP   = 4'b0000;
  localparam logic [3:0] ADD   = 4'b0001;
  localparam logic [3:0] JAL   = 4'b1000;

  typedef struct packed {
    logic [3:0]  aluc;
    logic [7:0]  alucex;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
  } pl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic ex_ready = 1'b0;
  logic ex_redirect = 1'b0;
  pl_t  cur = '0;

  logic             id_ready, id_ex_valid, id_ex_rd_wen;
  logic [3:0]       id_ex_aluc;
  logic [7:0]       id_ex_alucex;
  logic [4:0]       id_ex_rd_addr;
  logic [31:0]      id_ex_rs1_data, id_ex_rs2_data, id_ex_pc;
  logic [CNT_W-1:0] kill_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the pipe is a FIFO of at most two instructions whose
  // head is what execute sees, plus a saturating kill counter.
  pl_t mq[$];
  int  mkill = 0;
  bit  last_acc = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.NOP_ALUC(NOP), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_aluc        (cur.aluc),
    .id_alucex      (cur.alucex),
    .id_rd_addr     (cur.rd),
    .id_rd_wen      (cur.wen),
    .id_rs1_data    (cur.rs1),
    .id_rs2_data    (cur.rs2),
    .id_pc          (cur.pc),
    .id_ex_valid    (id_ex_valid),
    .ex_ready       (ex_ready),
    .ex_redirect    (ex_redirect),
    .id_ex_aluc     (id_ex_aluc),
    .id_ex_alucex   (id_ex_alucex),
    .id_ex_rd_addr  (id_ex_rd_addr),
    .id_ex_rd_wen   (id_ex_rd_wen),
    .id_ex_rs1_data (id_ex_rs1_data),
    .id_ex_rs2_data (id_ex_rs2_data),
    .id_ex_pc       (id_ex_pc),
    .kill_cnt       (kill_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] pc, input logic [3:0] aluc);
    pl_t p;
    p.aluc   = aluc;
    p.alucex = pc[9:2];
    p.rd     = pc[6:2] ^ 5'h1f;
    p.wen    = pc[2];
    p.rs1    = pc * 3 + 32'h1000;
    p.rs2    = ~pc;
    p.pc     = pc;
    return p;
  endfunction

  task automatic model_clear();
    mq.delete();
    mkill = 0;
  endtask

  // Apply one clock edge to the model, using the inputs the bench is driving.
  task automatic model_edge();
    bit acc, cons;
    int n;
    acc  = id_valid && (mq.size() < 2);
    cons = (mq.size() > 0) && ex_ready;
    if (cons && ex_redirect) begin
      n = mq.size() - 1 + int'(acc);
      mq.delete();
      mkill = mkill + n;
      if (mkill > (1 << CNT_W) - 1) mkill = (1 << CNT_W) - 1;
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(cur);
    end
    last_acc = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    pl_t exp_bus, act_bus;
    exp_bus = '0;
    exp_bus.aluc = NOP;
    if (mq.size() > 0) exp_bus = mq[0];
    act_bus = '{aluc: id_ex_aluc, alucex: id_ex_alucex, rd: id_ex_rd_addr,
                wen: id_ex_rd_wen, rs1: id_ex_rs1_data, rs2: id_ex_rs2_data,
                pc: id_ex_pc};
    chk("cyc_valid", id_ex_valid, mq.size() > 0);
    chk("cyc_bus", act_bus, exp_bus);
    chk("cyc_ready", id_ready, mq.size() < 2);
    chk("cyc_kill", kill_cnt, mkill);
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_ready", id_ready, 1);
    chk("rst_valid", id_ex_valid, 0);
    chk("rst_aluc", id_ex_aluc, NOP);
    chk("rst_kill", kill_cnt, 0);

    // Stream of ADDs at full throughput
    ex_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      id_valid = 1'b1;
      cur = mk(32'(4 * i), ADD);
      tick();
      chk("stream_pc", id_ex_pc, 32'(4 * i));
      chk("stream_valid", id_ex_valid, 1);
      chk("stream_ready", id_ready, 1);
    end
    id_valid = 1'b0;
    tick();

    // Backpressure: second instruction goes to the skid entry
    ex_ready = 1'b0;
    id_valid = 1'b1;
    cur = mk(32'h0, ADD);
    tick();
    cur = mk(32'h4, ADD);
    tick();
    chk("bp_ready_low", id_ready, 0);
    chk("bp_pc0", id_ex_pc, 32'h0);
    id_valid = 1'b0;
    ex_ready = 1'b1;
    tick();
    chk("bp_pc4", id_ex_pc, 32'h4);
    chk("bp_ready_back", id_ready, 1);
    tick();
    chk("bp_drained", id_ex_valid, 0);

    // JAL in M, 0xC in S; redirect without consume must hold everything
    ex_ready = 1'b0;
    id_valid = 1'b1;
    cur = mk(32'h8, JAL);
    tick();
    cur = mk(32'hC, ADD);
    tick();
    cur = mk(32'h10, ADD);
    ex_redirect = 1'b1;
    tick();
    chk("hold_pc", id_ex_pc, 32'h8);
    chk("hold_aluc", id_ex_aluc, JAL);
    chk("hold_ready", id_ready, 0);
    chk("hold_kill", kill_cnt, 0);
    // Now consume with redirect: 0xC killed, 0x10 not accepted (S was full)
    ex_ready = 1'b1;
    tick();
    chk("flush_valid", id_ex_valid, 0);
    chk("flush_aluc", id_ex_aluc, NOP);
    chk("flush_kill1", kill_cnt, 1);
    chk("flush_ready", id_ready, 1);
    // 0x10 lands in M, then a flush drops the accept of 0x14
    ex_ready = 1'b0;
    ex_redirect = 1'b0;
    tick();
    cur = mk(32'h14, ADD);
    ex_ready = 1'b1;
    ex_redirect = 1'b1;
    tick();
    chk("flush_kill2", kill_cnt, 2);
    chk("flush2_valid", id_ex_valid, 0);

    // Asynchronous reset with both entries full
    ex_ready = 1'b0;
    ex_redirect = 1'b0;
    id_valid = 1'b1;
    cur = mk(32'h30, ADD);
    tick();
    cur = mk(32'h34, ADD);
    tick();
    chk("pre_rst_ready", id_ready, 0);
    id_valid = 1'b0;
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    chk("arst_valid", id_ex_valid, 0);
    chk("arst_aluc", id_ex_aluc, NOP);
    chk("arst_pc", id_ex_pc, 0);
    chk("arst_ready", id_ready, 1);
    chk("arst_kill", kill_cnt, 0);
    #4 rst_n = 1'b1;

    // Saturation: five single-kill flushes on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      ex_ready = 1'b0;
      ex_redirect = 1'b0;
      id_valid = 1'b1;
      cur = mk(32'(32'h100 + 16 * i), ADD);
      tick();
      cur = mk(32'(32'h104 + 16 * i), ADD);
      tick();
      id_valid = 1'b0;
      ex_ready = 1'b1;
      ex_redirect = 1'b1;
      tick();
    end
    chk("sat_kill", kill_cnt, 3);
    ex_redirect = 1'b0;

    // Randomized traffic; decode holds a pending payload until accepted
    id_valid = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(id_valid && !last_acc)) begin
        id_valid = ($urandom_range(0, 3) != 0);
        cur = pl_t'({$urandom, $urandom, $urandom, $urandom});
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      tick();
    end

    id_valid = 1'b0;
    ex_redirect = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Elastic ID→EX pipeline register for the RV32 core.
- Captures one decoded instruction per cycle from decode and presents it on the id_ex_* bus that the execute stage consumes.
- Two-entry skid buffer, so backpressure does not create a combinational ready path back to decode.
- Kills wrong-path instructions when execute redirects the PC, and counts them.

Parameters:
- NOP_ALUC, 4'b0000, aluc code driven when no valid instruction; matches no type code, so execute defaults give rd_wen=0 and pc_wen=0.
- CNT_W, 16, width of the saturating killed-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  pipe can accept; registered
- id_aluc  in  4  decoded ALU class
- id_alucex  in  8  decoded ALU sub-op
- id_rd_addr  in  5  destination register
- id_rd_wen  in  1  destination write enable
- id_rs1_data  in  32  operand 1 (immU for LUI)
- id_rs2_data  in  32  operand 2 / immediate
- id_pc  in  32  instruction PC
- id_ex_valid  out  1  output entry valid
- ex_ready  in  1  execute consumes the output entry this cycle
- ex_redirect  in  1  execute PC write enable for the current output entry
- id_ex_aluc  out  4  to execute
- id_ex_alucex  out  8  to execute
- id_ex_rd_addr  out  5  to execute
- id_ex_rd_wen  out  1  to execute
- id_ex_rs1_data  out  32  to execute
- id_ex_rs2_data  out  32  to execute
- id_ex_pc  out  32  to execute
- kill_cnt  out  CNT_W  saturating count of squashed instructions

Behaviour:
- Storage: main entry M drives the id_ex_* outputs; skid entry S. Each has a valid bit.
- Events:
  - accept = id_valid & id_ready
  - consume = m_valid & ex_ready
  - flush = consume & ex_redirect
- id_ready = ~s_valid, from a flop. Decode may change payload only after accept.
- Latency: an instruction accepted at cycle N appears on the outputs at N+1 if M is free or being consumed.
- Update rules, evaluated on each rising clk edge in priority order:
  - flush: M is consumed (the jump itself retires to execute). S is cleared and the incoming accept is dropped. kill_cnt += s_valid + accept, saturating at all-ones.
  - M empty or consume, with s_valid: M←S, s_valid←0. accept is impossible because id_ready=0.
  - M empty or consume, no s_valid: M←incoming if accept, else m_valid←0.
  - M full, no consume, accept: S←incoming.
  - Otherwise: hold.
- Ordering: instructions leave in acceptance order. There is no loss or duplication except via flush.
- ex_redirect is ignored when ~m_valid or ~ex_ready; no flush occurs and the entry is held.
- Output masking when ~m_valid:
  - id_ex_aluc = NOP_ALUC
  - id_ex_alucex, id_ex_rd_addr, id_ex_rd_wen, id_ex_rs1_data, id_ex_rs2_data, id_ex_pc = 0
  - This is a combinational mask on the registered fields.
- Reset (asynchronous, rst_n=0):
  - m_valid = s_valid = 0
  - id_ready = 1
  - all id_ex_* outputs at masked values
  - kill_cnt = 0
  - Any in-flight entries are discarded. The first accept is allowed on the first edge after rst_n rises.
- Full throughput: with ex_ready held high, one instruction per cycle, and S is never used.

Decomposition:
- Add NOP_ALUC (4'b0000) to define.v, next to the existing aluc/alucex type codes.
- Add a packed payload width constant, IDEX_W = 4+8+5+1+32+32+32 = 114, to define.v.
- One sub-module, idex_slot: a payload register with valid, load and clear, built on clk/rst_n. Instantiate it twice, as M and S.

Test Plan:
- Stream: 5 ADD instructions (id_pc 0x0,0x4,…) with ex_ready=1.
  - id_ex_pc is 0x0..0x10 on consecutive cycles, each 1 cycle after accept.
  - id_ready stays 1.
- Backpressure: ex_ready=0 while 2 instructions are sent.
  - The second lands in S and id_ready drops to 0 the next cycle.
  - After ex_ready=1, outputs are pc 0x0 then 0x4, and id_ready returns to 1.
- Flush: M holds JAL at pc 0x8, S holds pc 0xC, decode presents pc 0x10 while id_ready=1 after the drain; assert ex_redirect=ex_ready=1.
  - Next cycle id_ex_valid=0 and id_ex_aluc=NOP_ALUC.
  - kill_cnt counts 0xC plus the pc 0x10 accept if accepted in that cycle.
- Redirect without consume: ex_redirect=1, ex_ready=0.
  - M is held, S is kept, kill_cnt is unchanged.
- Reset mid-operation: assert rst_n=0 with M and S full.
  - Outputs are masked immediately (asynchronous), id_ready=1, kill_cnt=0.
- Saturation: with CNT_W=2, trigger 5 single-kill flushes.
  - kill_cnt sticks at 3.
